// File: rtl/cpu_defs_pkg.sv
// Shared CP0 definitions: register numbers, address layout, Cause.IP bit positions.
package cpu_defs;

  localparam logic [4:0] CR_COUNT   = 5'd9;
  localparam logic [4:0] CR_COMPARE = 5'd11;
  localparam logic [4:0] CR_CAUSE   = 5'd13;

  typedef struct packed {
    logic [4:0] rnum;
    logic [2:0] sel;
  } cp0_addr_t;

  localparam int IP_TIMER = 7;
  localparam int IP_SW0   = 0;
  localparam int IP_HW0   = 2;

  // Index of the highest set bit, 0 when the vector is empty.
  function automatic logic [2:0] msb_idx8(input logic [7:0] v);
    logic [2:0] r;
    r = '0;
    for (int i = 0; i < 8; i++)
      if (v[i]) r = 3'(i);
    return r;
  endfunction

endpackage

// File: rtl/cp0_sync_bit.sv
// Single-bit synchroniser, STAGES flops deep; STAGES=0 is a plain wire.
module cp0_sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  if (STAGES == 0) begin : g_wire
    assign q = d;
  end else begin : g_flops
    logic [STAGES-1:0] sr;
    // Shift the async input through the flop chain.
    always_ff @(posedge clk) begin
      if (reset) sr <= '0;
      else begin
        sr[0] <= d;
        for (int j = 1; j < STAGES; j++) sr[j] <= sr[j-1];
      end
    end
    assign q = sr[STAGES-1];
  end

endmodule

// File: rtl/cp0_timer_intc.sv
// CP0 Count/Compare timer channels plus Cause.IP collection and interrupt priority.
module cp0_timer_intc
  import cpu_defs::*;
#(
  parameter int N_CMP       = 1,
  parameter int COUNT_DIV   = 2,
  parameter int SYNC_STAGES = 2,
  parameter int N_EXT       = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              c0_we,
  input  logic [7:0]        c0_addr,
  input  logic [31:0]       c0_wdata,
  output logic [31:0]       c0_rdata,
  input  logic              count_stop,
  input  logic [N_EXT-1:0]  ext_int_in,
  input  logic              status_ie,
  input  logic              status_exl,
  input  logic [7:0]        status_im,
  output logic [7:0]        cause_ip,
  output logic [N_CMP-1:0]  ti,
  output logic              int_req,
  output logic [2:0]        int_line,
  output logic [31:0]       count
);

  localparam int PW = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;

  cp0_addr_t a;
  assign a = cp0_addr_t'(c0_addr);

  logic wr_count, wr_cause;
  assign wr_count = c0_we && (a.rnum == CR_COUNT) && (a.sel == 3'd0);
  assign wr_cause = c0_we && (a.rnum == CR_CAUSE) && (a.sel == 3'd0);

  logic [PW-1:0] pre;
  logic          tick;
  logic [31:0]   count_q;
  assign tick  = (pre == PW'(COUNT_DIV - 1));
  assign count = count_q;

  // Prescaler and Count; a Count write beats both tick and count_stop.
  always_ff @(posedge clk) begin
    if (reset) begin
      pre     <= '0;
      count_q <= '0;
    end else if (wr_count) begin
      pre     <= '0;
      count_q <= c0_wdata;
    end else if (!count_stop) begin
      pre <= tick ? '0 : pre + PW'(1);
      if (tick) count_q <= count_q + 32'd1;
    end
  end

  logic [N_CMP-1:0][31:0] cmp;

  for (genvar i = 0; i < N_CMP; i++) begin : g_cmp
    logic        wr;
    logic [31:0] cmp_r;
    logic        ti_r;
    assign wr = c0_we && (a.rnum == CR_COMPARE) && (a.sel == 3'(i));
    // Compare register and sticky flag; the write-clear wins over a match.
    always_ff @(posedge clk) begin
      if (reset) begin
        cmp_r <= '1;
        ti_r  <= 1'b0;
      end else if (wr) begin
        cmp_r <= c0_wdata;
        ti_r  <= 1'b0;
      end else if (count_q == cmp_r) begin
        ti_r  <= 1'b1;
      end
    end
    assign cmp[i] = cmp_r;
    assign ti[i]  = ti_r;
  end

  logic [N_EXT-1:0] ext_s;
  logic [5:0]       ext6;

  for (genvar k = 0; k < N_EXT; k++) begin : g_sync
    cp0_sync_bit #(.STAGES(SYNC_STAGES)) u_sync (
      .clk   (clk),
      .reset (reset),
      .d     (ext_int_in[k]),
      .q     (ext_s[k])
    );
  end

  // Widen the synchronised lines to the full six hardware slots.
  always_comb begin
    ext6 = '0;
    ext6[N_EXT-1:0] = ext_s;
  end

  logic [7:0] ip_q;
  assign cause_ip = ip_q;

  // Hardware IP bits resample every cycle; software bits move only on a Cause write.
  always_ff @(posedge clk) begin
    if (reset) ip_q <= '0;
    else begin
      ip_q[IP_TIMER]    <= ext6[5] | (|ti);
      ip_q[IP_HW0 +: 5] <= ext6[4:0];
      if (wr_cause) ip_q[IP_SW0 +: 2] <= c0_wdata[9:8];
    end
  end

  logic [7:0] masked;
  assign masked   = ip_q & status_im;
  assign int_req  = status_ie & ~status_exl & (|masked);
  assign int_line = msb_idx8(masked);

  // Read mux for the registers this block owns; everything else reads 0.
  always_comb begin
    c0_rdata = '0;
    case (a.rnum)
      CR_COUNT: if (a.sel == 3'd0) c0_rdata = count_q;
      CR_COMPARE:
        for (int i = 0; i < N_CMP; i++)
          if (a.sel == 3'(i)) c0_rdata = cmp[i];
      CR_CAUSE: if (a.sel == 3'd0) c0_rdata = {1'b0, |ti, 14'b0, ip_q, 8'b0};
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cp0_timer_intc.sv
// Directed bench for cp0_timer_intc with N_CMP=2, COUNT_DIV=2, SYNC_STAGES=2, N_EXT=6.
module tb_cp0_timer_intc;
  import cpu_defs::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        c0_we;
  logic [7:0]  c0_addr;
  logic [31:0] c0_wdata;
  logic [31:0] c0_rdata;
  logic        count_stop;
  logic [5:0]  ext_int_in;
  logic        status_ie, status_exl;
  logic [7:0]  status_im;
  logic [7:0]  cause_ip;
  logic [1:0]  ti;
  logic        int_req;
  logic [2:0]  int_line;
  logic [31:0] count;

  int vectors = 0;
  int errors  = 0;

  cp0_timer_intc #(.N_CMP(2), .COUNT_DIV(2), .SYNC_STAGES(2), .N_EXT(6)) dut (
    .clk        (clk),
    .reset      (reset),
    .c0_we      (c0_we),
    .c0_addr    (c0_addr),
    .c0_wdata   (c0_wdata),
    .c0_rdata   (c0_rdata),
    .count_stop (count_stop),
    .ext_int_in (ext_int_in),
    .status_ie  (status_ie),
    .status_exl (status_exl),
    .status_im  (status_im),
    .cause_ip   (cause_ip),
    .ti         (ti),
    .int_req    (int_req),
    .int_line   (int_line),
    .count      (count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic wr(input logic [4:0] r, input logic [2:0] s, input logic [31:0] d);
    c0_addr = {r, s}; c0_wdata = d; c0_we = 1'b1;
    step();
    c0_we = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; step(); reset = 1'b0;
    vectors++; if (count !== 32'd0) begin errors++; $display("FAIL reset_count got %h exp 0", count); end
    vectors++; if (ti !== 2'b00) begin errors++; $display("FAIL reset_ti got %b exp 00", ti); end
    vectors++; if (cause_ip !== 8'h00) begin errors++; $display("FAIL reset_ip got %h exp 00", cause_ip); end
    vectors++; if (int_req !== 1'b0 || int_line !== 3'd0) begin errors++; $display("FAIL reset_int got %b/%0d exp 0/0", int_req, int_line); end
    c0_addr = {CR_COMPARE, 3'd1}; #1;
    vectors++; if (c0_rdata !== 32'hFFFF_FFFF) begin errors++; $display("FAIL reset_cmp1 got %h exp ffffffff", c0_rdata); end
    c0_addr = {5'd12, 3'd0}; #1;
    vectors++; if (c0_rdata !== 32'd0) begin errors++; $display("FAIL unowned_read got %h exp 0", c0_rdata); end
  endtask

  task automatic test_count();
    wr(CR_COUNT, 3'd0, 32'd5);
    repeat (10) step();
    vectors++; if (count !== 32'd10) begin errors++; $display("FAIL count_div got %h exp 0000000a", count); end
    wr(CR_COUNT, 3'd0, 32'hFFFF_FFFF);
    repeat (2) step();
    vectors++; if (count !== 32'd0) begin errors++; $display("FAIL count_wrap got %h exp 0", count); end
    // Both Compare registers still hold FFFFFFFF, so both flags latched on the way past.
    vectors++; if (ti !== 2'b11) begin errors++; $display("FAIL ti_reset_cmp got %b exp 11", ti); end
  endtask

  task automatic test_timer();
    wr(CR_COMPARE, 3'd0, 32'h20);
    wr(CR_COMPARE, 3'd1, 32'h40);
    vectors++; if (ti !== 2'b00) begin errors++; $display("FAIL ti_cleared got %b exp 00", ti); end
    wr(CR_COUNT, 3'd0, 32'h1E);
    repeat (5) step();
    vectors++; if (ti !== 2'b01 || count !== 32'h20) begin errors++; $display("FAIL ti0_set got %b/%h exp 01/00000020", ti, count); end
    vectors++; if (cause_ip[7] !== 1'b0) begin errors++; $display("FAIL ip7_early got %b exp 0", cause_ip[7]); end
    step();
    vectors++; if (cause_ip[7] !== 1'b1) begin errors++; $display("FAIL ip7_late got %b exp 1", cause_ip[7]); end
    repeat (63) step();
    vectors++; if (ti !== 2'b11 || count !== 32'h40) begin errors++; $display("FAIL ti1_set got %b/%h exp 11/00000040", ti, count); end
    wr(CR_COMPARE, 3'd0, 32'h100);
    vectors++; if (ti !== 2'b10) begin errors++; $display("FAIL ti0_clear got %b exp 10", ti); end
    wr(CR_COMPARE, 3'd2, 32'h0);
    c0_addr = {CR_COMPARE, 3'd2}; #1;
    vectors++; if (c0_rdata !== 32'd0 || ti !== 2'b10) begin errors++; $display("FAIL cmp_sel2 got %h/%b exp 0/10", c0_rdata, ti); end
  endtask

  task automatic test_clear_vs_set();
    count_stop = 1'b1;
    wr(CR_COUNT, 3'd0, 32'h54);
    wr(CR_COMPARE, 3'd0, 32'h55);
    wr(CR_COUNT, 3'd0, 32'h55);
    wr(CR_COMPARE, 3'd0, 32'h55);
    vectors++; if (ti[0] !== 1'b0) begin errors++; $display("FAIL clear_wins got %b exp 0", ti[0]); end
    step();
    vectors++; if (ti[0] !== 1'b1) begin errors++; $display("FAIL set_after got %b exp 1", ti[0]); end
  endtask

  task automatic test_count_stop();
    repeat (6) step();
    vectors++; if (count !== 32'h55) begin errors++; $display("FAIL count_stop got %h exp 00000055", count); end
  endtask

  task automatic test_ext();
    ext_int_in[2] = 1'b1;
    step();
    vectors++; if (cause_ip[4] !== 1'b0) begin errors++; $display("FAIL ext_t1 got %b exp 0", cause_ip[4]); end
    step();
    vectors++; if (cause_ip[4] !== 1'b0) begin errors++; $display("FAIL ext_t2 got %b exp 0", cause_ip[4]); end
    step();
    vectors++; if (cause_ip[4] !== 1'b1) begin errors++; $display("FAIL ext_t3 got %b exp 1", cause_ip[4]); end
    status_im = 8'h10; status_ie = 1'b1; status_exl = 1'b0; #1;
    vectors++; if (int_req !== 1'b1 || int_line !== 3'd4) begin errors++; $display("FAIL ext_int got %b/%0d exp 1/4", int_req, int_line); end
    status_exl = 1'b1; #1;
    vectors++; if (int_req !== 1'b0) begin errors++; $display("FAIL exl_mask got %b exp 0", int_req); end
    status_exl = 1'b0; status_im = 8'hFF; #1;
    vectors++; if (int_req !== 1'b1 || int_line !== 3'd7) begin errors++; $display("FAIL prio7 got %b/%0d exp 1/7", int_req, int_line); end
    ext_int_in = '0;
    repeat (3) step();
  endtask

  task automatic test_sw();
    status_im = 8'h00;
    wr(CR_COMPARE, 3'd0, 32'h100);
    wr(CR_COMPARE, 3'd1, 32'h100);
    c0_addr = {CR_CAUSE, 3'd0}; c0_wdata = 32'h200; c0_we = 1'b1; #1;
    vectors++; if (c0_rdata !== 32'h0000_8000) begin errors++; $display("FAIL rd_old got %h exp 00008000", c0_rdata); end
    step(); c0_we = 1'b0; #1;
    vectors++; if (cause_ip[1] !== 1'b1 || c0_rdata !== 32'h0000_0200) begin errors++; $display("FAIL sw_rd got %h/%h exp 02/00000200", cause_ip, c0_rdata); end
    status_im = 8'h02; status_ie = 1'b1; #1;
    vectors++; if (int_req !== 1'b1 || int_line !== 3'd1) begin errors++; $display("FAIL sw_int got %b/%0d exp 1/1", int_req, int_line); end
    repeat (3) step();
    vectors++; if (cause_ip !== 8'h02) begin errors++; $display("FAIL sw_hold got %h exp 02", cause_ip); end
  endtask

  task automatic test_reset_mid();
    wr(CR_COMPARE, 3'd0, 32'h55);
    repeat (2) step();
    vectors++; if (ti !== 2'b01 || cause_ip !== 8'h82) begin errors++; $display("FAIL pre_reset got %b/%h exp 01/82", ti, cause_ip); end
    reset = 1'b1; step(); reset = 1'b0;
    vectors++; if (count !== 32'd0 || ti !== 2'b00 || cause_ip !== 8'h00) begin errors++; $display("FAIL mid_reset got %h/%b/%h exp 0/00/00", count, ti, cause_ip); end
    vectors++; if (int_req !== 1'b0 || int_line !== 3'd0) begin errors++; $display("FAIL mid_reset_int got %b/%0d exp 0/0", int_req, int_line); end
    c0_addr = {CR_COMPARE, 3'd0}; #1;
    vectors++; if (c0_rdata !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mid_reset_cmp0 got %h exp ffffffff", c0_rdata); end
    c0_addr = {CR_CAUSE, 3'd0}; #1;
    vectors++; if (c0_rdata !== 32'd0) begin errors++; $display("FAIL mid_reset_cause got %h exp 0", c0_rdata); end
    step();
    vectors++; if (ti !== 2'b00) begin errors++; $display("FAIL no_ti_pulse got %b exp 00", ti); end
  endtask

  initial begin
    reset = 1'b1; c0_we = 1'b0; c0_addr = '0; c0_wdata = '0;
    count_stop = 1'b0; ext_int_in = '0;
    status_ie = 1'b0; status_exl = 1'b0; status_im = '0;
    #1;
    test_reset();
    test_count();
    test_timer();
    test_clear_vs_set();
    test_count_stop();
    test_ext();
    test_sw();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
